// File: rtl/axil_lfsr_hist_if.sv
// rtl/axil_lfsr_hist_if.sv - AXI-Lite register port and AXI-Stream sample port of axil_lfsr_hist
interface axil_lfsr_hist_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/axil_lfsr_hist.sv
// rtl/axil_lfsr_hist.sv - AXI-Lite programmed LFSR stream source with readable bin histogram
module axil_lfsr_hist #(
    parameter int          C_AXIL_ADDR_WIDTH = 8,
    parameter int          C_AXIL_DATA_WIDTH = 32,
    parameter int          DATA_WIDTH        = 32,
    parameter int          BIN_BITS          = 3,
    parameter int          COUNT_WIDTH       = 16,
    parameter logic [31:0] DEFAULT_TAPS      = 32'h8020_0003
) (
    input  logic            aclk,
    input  logic            areset,
    axil_lfsr_hist_if.slave bus,
    output logic            done
);
    localparam int NUM_BINS = 1 << BIN_BITS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]        seed_q, taps_q, lfsr_q, lfsr_next;
    logic [31:0]                  length_q, sent_q;
    logic [COUNT_WIDTH-1:0]       bin_q [NUM_BINS];
    logic                         abort_q;
    logic                         awready_q, arready_q, bvalid_q, rvalid_q;
    logic [1:0]                   bresp_q, rresp_q;
    logic [C_AXIL_DATA_WIDTH-1:0] rdata_q;

    logic [C_AXIL_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [4:0]                   wr_word, rd_word;
    logic                         wr_hi_ok, rd_hi_ok, wr_fire, rd_fire, wr_err;
    logic                         ctrl_wr, start_wr, clear_wr, abort_wr;
    logic                         run, hs, tlast;
    logic [BIN_BITS-1:0]          bin_idx;
    logic [31:0]                  rd_data;
    logic                         rd_err;
    logic                         unused_addr_lsbs;

    // Address decode: bits [1:0] are ignored, anything above 0x7F is unmapped
    assign wr_addr          = bus.s_axi_awaddr;
    assign rd_addr          = bus.s_axi_araddr;
    assign wr_word          = wr_addr[6:2];
    assign rd_word          = rd_addr[6:2];
    assign wr_hi_ok         = (wr_addr >> 7) == '0;
    assign rd_hi_ok         = (rd_addr >> 7) == '0;
    assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

    assign wr_fire  = awready_q & bus.s_axi_awvalid & bus.s_axi_wvalid;
    assign rd_fire  = arready_q & bus.s_axi_arvalid;
    assign wr_err   = !wr_hi_ok || (!wr_word[4] && (wr_word > 5'd5));
    assign ctrl_wr  = wr_fire && wr_hi_ok && (wr_word == 5'd0);
    assign start_wr = ctrl_wr & bus.s_axi_wdata[0];
    assign clear_wr = ctrl_wr & bus.s_axi_wdata[1];
    assign abort_wr = ctrl_wr & bus.s_axi_wdata[2];

    // Stream side: the presented beat is the current LFSR word
    assign run       = (state_q == S_RUN);
    assign hs        = run & bus.m_axis_tready;
    assign tlast     = run && ((sent_q == length_q - 32'd1) || abort_q);
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
    assign bin_idx   = lfsr_q[DATA_WIDTH-1 -: BIN_BITS];

    assign bus.m_axis_tvalid = run;
    assign bus.m_axis_tdata  = run ? lfsr_q : '0;
    assign bus.m_axis_tlast  = tlast;
    assign done              = (state_q == S_DONE);

    assign bus.s_axi_awready = awready_q;
    assign bus.s_axi_wready  = awready_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign bus.s_axi_rdata   = rdata_q;

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: START only acts outside RUN, a tlast handshake ends the run
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_wr) state_d = (length_q == 32'd0) ? S_DONE : S_RUN;
            S_RUN:          if (hs && tlast) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Generator: load on START, advance per accepted beat, track pending abort
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q  <= '0;
            sent_q  <= '0;
            abort_q <= 1'b0;
        end else if (start_wr && !run) begin
            lfsr_q  <= (seed_q == '0) ? DATA_WIDTH'(1) : seed_q;
            sent_q  <= '0;
            abort_q <= 1'b0;
        end else if (run) begin
            if (hs) begin
                lfsr_q <= lfsr_next;
                sent_q <= sent_q + 32'd1;
            end
            if (hs && tlast) abort_q <= 1'b0;
            else if (abort_wr) abort_q <= 1'b1;
        end
    end

    // Histogram: CLEAR beats a same-cycle handshake, counters stick at all-ones
    always_ff @(posedge aclk) begin
        if (areset || clear_wr) begin
            for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
        end else if (hs && (bin_q[bin_idx] != '1)) begin
            bin_q[bin_idx] <= bin_q[bin_idx] + COUNT_WIDTH'(1);
        end
    end

    // Configuration registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            seed_q   <= DATA_WIDTH'(1);
            length_q <= '0;
            taps_q   <= DEFAULT_TAPS[DATA_WIDTH-1:0];
        end else if (wr_fire && wr_hi_ok) begin
            case (wr_word)
                5'd2:    seed_q   <= bus.s_axi_wdata[DATA_WIDTH-1:0];
                5'd3:    length_q <= bus.s_axi_wdata;
                5'd4:    taps_q   <= bus.s_axi_wdata[DATA_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Read mux: bins live at 0x40.., unimplemented bin slots read 0 without error
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (!rd_hi_ok) begin
            rd_err = 1'b1;
        end else if (rd_word[4]) begin
            if ((rd_word[3:0] >> BIN_BITS) == 4'd0)
                rd_data[COUNT_WIDTH-1:0] = bin_q[rd_word[BIN_BITS-1:0]];
        end else begin
            case (rd_word[3:0])
                4'd0:    rd_data = '0;
                4'd1:    rd_data = {30'd0, done, run};
                4'd2:    rd_data[DATA_WIDTH-1:0] = seed_q;
                4'd3:    rd_data = length_q;
                4'd4:    rd_data[DATA_WIDTH-1:0] = taps_q;
                4'd5:    rd_data = sent_q;
                default: rd_err = 1'b1;
            endcase
        end
    end

    // AXI-Lite handshakes: single outstanding write and read, ready pulses one cycle
    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            awready_q <= bus.s_axi_awvalid & bus.s_axi_wvalid & !bvalid_q & !awready_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? 2'b10 : 2'b00;
            end else if (bvalid_q && bus.s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= bus.s_axi_arvalid & !rvalid_q & !arready_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_err ? 2'b10 : 2'b00;
            end else if (rvalid_q && bus.s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_lfsr_hist.sv
// tb/tb_axil_lfsr_hist.sv - self-checking bench for axil_lfsr_hist
module tb_axil_lfsr_hist;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int BB   = 3;
    localparam int CW   = 2;
    localparam int NB   = 1 << BB;
    localparam int CMAX = (1 << CW) - 1;

    localparam int A_CTRL   = 'h00;
    localparam int A_STATUS = 'h04;
    localparam int A_SEED   = 'h08;
    localparam int A_LENGTH = 'h0C;
    localparam int A_TAPS   = 'h10;
    localparam int A_SENT   = 'h14;
    localparam int A_BIN    = 'h40;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    logic done;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rmode    = 0;
    int   wr_cyc   = 0;
    int   done_cyc = 0;

    beat_t         beats[$];
    logic [DW-1:0] exp_q[$];
    int            exp_bins[NB];
    logic [7:0]    basic_data[5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
    int            basic_bins[NB] = '{2, 1, 1, 0, 0, 1, 0, 0};

    axil_lfsr_hist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_lfsr_hist #(
        .C_AXIL_ADDR_WIDTH(AW), .C_AXIL_DATA_WIDTH(32), .DATA_WIDTH(DW),
        .BIN_BITS(BB), .COUNT_WIDTH(CW), .DEFAULT_TAPS(32'h8020_0003)
    ) dut (
        .aclk(aclk), .areset(areset), .bus(bus), .done(done)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev  = '0;

    always @(negedge aclk) begin
        if (stall_prev && !areset) begin
            check("stall_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
            check("stall_tdata", 32'(bus.m_axis_tdata), 32'(data_prev));
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready)
            beats.push_back('{bus.m_axis_tdata, bus.m_axis_tlast, cyc});
        stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready && !areset;
        data_prev  = bus.m_axis_tdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk); #1;
        if (rmode == 1)      bus.m_axis_tready = ~bus.m_axis_tready;
        else if (rmode == 2) bus.m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic axil_write(input int addr, input logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        bus.s_axi_awaddr  = AW'(addr);
        bus.s_axi_wdata   = data;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        while (!bus.s_axi_awready && n < 20) begin step(); n++; end
        check("awready_wready", 32'(bus.s_axi_awready && bus.s_axi_wready), 32'd1);
        wr_cyc = cyc;
        step();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        check("bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        resp = bus.s_axi_bresp;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        logic [1:0] r;
        axil_write(addr, data, r);
    endtask

    task automatic axil_read(input int addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        bus.s_axi_araddr  = AW'(addr);
        bus.s_axi_arvalid = 1'b1;
        while (!bus.s_axi_arready && n < 20) begin step(); n++; end
        check("arready", 32'(bus.s_axi_arready), 32'd1);
        step();
        bus.s_axi_arvalid = 1'b0;
        check("rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        data = bus.s_axi_rdata;
        resp = bus.s_axi_rresp;
    endtask

    task automatic rd_check(input string tag, input int addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axil_read(addr, d, r);
        check({tag, "_data"}, d, exp);
        check({tag, "_resp"}, 32'(r), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 500) begin step(); n++; end
        done_cyc = cyc;
        check("done_reached", 32'(done), 32'd1);
        check("tvalid_after_done", 32'(bus.m_axis_tvalid), 32'd0);
    endtask

    task automatic model_run(input logic [DW-1:0] seed, input logic [DW-1:0] taps, input int len);
        int x = (seed == 0) ? 1 : int'(seed);
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(DW'(x));
            x = (x % 2 == 1) ? ((x / 2) ^ int'(taps)) : (x / 2);
        end
    endtask

    task automatic model_bins(input int after_cyc);
        for (int k = 0; k < NB; k++) exp_bins[k] = 0;
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            if (beats[i].cyc > after_cyc) begin
                int k;
                k = int'(exp_q[i]) / (1 << (DW - BB));
                if (exp_bins[k] < CMAX) exp_bins[k]++;
            end
        end
    endtask

    task automatic check_run(input int len);
        check("beat_count", 32'(beats.size()), 32'(len));
        for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
            check("beat_data", 32'(beats[i].data), 32'(exp_q[i]));
            check("beat_last", 32'(beats[i].last), 32'(i == len - 1));
        end
        for (int i = 0; i < NB; i++) rd_check("bin", A_BIN + 4 * i, 32'(exp_bins[i]));
        rd_check("sent", A_SENT, 32'(len));
        rd_check("status", A_STATUS, 32'd2);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        int          hit;
        logic [DW-1:0] s, t;
        int          len;

        bus.s_axi_awaddr  = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b1;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b1;
        bus.m_axis_tready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        check("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        check("rst_wready", 32'(bus.s_axi_wready), 32'd0);
        check("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        check("rst_bresp", 32'(bus.s_axi_bresp), 32'd0);
        check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        check("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        check("rst_rresp", 32'(bus.s_axi_rresp), 32'd0);
        check("rst_rdata", bus.s_axi_rdata, 32'd0);
        areset = 1'b0;
        step();
        rd_check("rst_status", A_STATUS, 32'd0);
        rd_check("rst_seed", A_SEED, 32'd1);
        rd_check("rst_length", A_LENGTH, 32'd0);
        rd_check("rst_taps", A_TAPS, 32'h03);
        rd_check("rst_sent", A_SENT, 32'd0);
        rd_check("ctrl_reads_zero", A_CTRL, 32'd0);
        for (int i = 0; i < NB; i++) rd_check("rst_bin", A_BIN + 4 * i, 32'd0);

        // LENGTH = 0: straight to DONE, no beats
        beats.delete();
        wr(A_CTRL, 32'h1);
        check("len0_done", 32'(done), 32'd1);
        check("len0_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        repeat (3) step();
        check("len0_beats", 32'(beats.size()), 32'd0);
        rd_check("len0_sent", A_SENT, 32'd0);

        // Basic run against the literal reference sequence
        wr(A_TAPS, 32'hB8);
        wr(A_SEED, 32'h01);
        wr(A_LENGTH, 32'd5);
        beats.delete();
        wr(A_CTRL, 32'h1);
        check("start_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        check("start_tdata", 32'(bus.m_axis_tdata), 32'h01);
        check("start_not_done", 32'(done), 32'd0);
        wait_done();
        check("basic_count", 32'(beats.size()), 32'd5);
        for (int i = 0; i < beats.size() && i < 5; i++) begin
            check("basic_data", 32'(beats[i].data), 32'(basic_data[i]));
            check("basic_last", 32'(beats[i].last), 32'(i == 4));
        end
        if (beats.size() == 5) begin
            check("basic_throughput", 32'(beats[4].cyc - beats[0].cyc), 32'd4);
            check("basic_done_latency", 32'(done_cyc), 32'(beats[4].cyc + 1));
        end
        for (int i = 0; i < NB; i++) rd_check("basic_bin", A_BIN + 4 * i, 32'(basic_bins[i]));
        rd_check("basic_sent", A_SENT, 32'd5);
        rd_check("basic_status", A_STATUS, 32'd2);

        // Backpressure: tready toggles, START and CLEAR in one word
        rmode = 1;
        beats.delete();
        wr(A_CTRL, 32'h3);
        wait_done();
        rmode = 0;
        bus.m_axis_tready = 1'b1;
        model_run(8'h01, 8'hB8, 5);
        model_bins(wr_cyc);
        check_run(5);

        // Abort while the fourth beat is stalled
        wr(A_LENGTH, 32'd100);
        beats.delete();
        wr(A_CTRL, 32'h3);
        n = 0;
        while (beats.size() < 3 && n < 50) begin step(); n++; end
        bus.m_axis_tready = 1'b0;
        wr(A_CTRL, 32'h4);
        repeat (3) step();
        check("abort_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        check("abort_tdata", 32'(bus.m_axis_tdata), 32'h2E);
        check("abort_tlast", 32'(bus.m_axis_tlast), 32'd1);
        check("abort_not_done", 32'(done), 32'd0);
        bus.m_axis_tready = 1'b1;
        wait_done();
        repeat (5) step();
        check("abort_beats", 32'(beats.size()), 32'd4);
        if (beats.size() == 4) begin
            check("abort_last_data", 32'(beats[3].data), 32'h2E);
            check("abort_last_flag", 32'(beats[3].last), 32'd1);
        end
        rd_check("abort_sent", A_SENT, 32'd4);

        // SEED 0 behaves as seed 1
        wr(A_SEED, 32'h0);
        wr(A_LENGTH, 32'd3);
        beats.delete();
        wr(A_CTRL, 32'h3);
        wait_done();
        model_run(8'h00, 8'hB8, 3);
        model_bins(wr_cyc);
        check_run(3);

        // START during RUN is ignored
        wr(A_SEED, 32'h5A);
        wr(A_LENGTH, 32'd20);
        beats.delete();
        wr(A_CTRL, 32'h3);
        step();
        wr(A_CTRL, 32'h1);
        wait_done();
        model_run(8'h5A, 8'hB8, 20);
        model_bins(-1);
        check_run(20);

        // CLEAR landing on a handshake: that beat and earlier ones are dropped
        wr(A_SEED, 32'h01);
        wr(A_LENGTH, 32'd40);
        beats.delete();
        wr(A_CTRL, 32'h3);
        repeat (5) step();
        wr(A_CTRL, 32'h2);
        n = wr_cyc;
        wait_done();
        hit = 0;
        foreach (beats[i]) if (beats[i].cyc == n) hit++;
        check("clear_hits_beat", 32'(hit), 32'd1);
        model_run(8'h01, 8'hB8, 40);
        model_bins(n);
        check_run(40);

        // CLEAR in DONE zeroes every bin
        wr(A_CTRL, 32'h2);
        for (int i = 0; i < NB; i++) rd_check("clear_bin", A_BIN + 4 * i, 32'd0);

        // AXI-Lite error and read-only handling
        axil_read('h20, d, r);
        check("unmapped_rdata", d, 32'd0);
        check("unmapped_rresp", 32'(r), 32'd2);
        axil_write('h04, 32'hFF, r);
        check("ro_write_bresp", 32'(r), 32'd0);
        rd_check("ro_status_kept", A_STATUS, 32'd2);
        axil_write('h20, 32'h1234, r);
        check("unmapped_bresp", 32'(r), 32'd2);
        rd_check("bin_slot_78", 'h78, 32'd0);

        // Randomised runs with random backpressure
        for (int k = 0; k < 4; k++) begin
            s   = DW'($urandom);
            t   = DW'($urandom) | 8'h80;
            len = int'($urandom_range(1, 40));
            rmode = 2;
            wr(A_SEED, 32'(s));
            wr(A_TAPS, 32'(t));
            wr(A_LENGTH, 32'(len));
            beats.delete();
            wr(A_CTRL, 32'h3);
            wait_done();
            rmode = 0;
            bus.m_axis_tready = 1'b1;
            model_run(s, t, len);
            model_bins(wr_cyc);
            check_run(len);
        end

        // Reset in mid-run truncates the burst
        wr(A_LENGTH, 32'd50);
        beats.delete();
        wr(A_CTRL, 32'h3);
        repeat (5) step();
        areset = 1'b1;
        step();
        check("mrst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("mrst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        check("mrst_tdata", 32'(bus.m_axis_tdata), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        check("mrst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        areset = 1'b0;
        step();
        hit = 0;
        foreach (beats[i]) if (beats[i].last) hit++;
        check("mrst_no_tlast", 32'(hit), 32'd0);
        rd_check("mrst_status", A_STATUS, 32'd0);
        rd_check("mrst_sent", A_SENT, 32'd0);
        rd_check("mrst_seed", A_SEED, 32'd1);
        rd_check("mrst_taps", A_TAPS, 32'h03);
        rd_check("mrst_bin0", A_BIN, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
